ddr2_port_arbiter: RTL and testbench

//  Shares one DDR2 user port (req/ack/addr/read/data_write/mask; valid/data_read)

---
 rtl/ddr2_port_arbiter.sv | 131 +++++++++++++
 tb/tb_ddr2_port_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ddr2_port_arbiter.sv
// ddr2_port_arbiter
//   Shares one DDR2 user port between two sequential clients (c0, c1).
//   Round-robin grant, held for one burst of up to MAX_BURST acks. Read-return
//   beats go to the client that issued the reads. The grant is not handed to
//   the other client until every outstanding read beat has come back.
// Ports
//   ddr2_clk, RST       clock (posedge) and asynchronous active-low reset
//   c_req/c_read/c_fin  per-client request, read flag, end-of-burst hint
//   c_addr/c_data_write/c_mask  {c1,c0} packed request payloads
//   c_ack/c_valid       per-client ack and read-data valid
//   c_data_read         read data, broadcast to both clients
//   m_*                 DDR2 user-port side
//   owner               current or last grantee
//   err_stray           sticky flag: read beat arrived with nothing outstanding
module ddr2_port_arbiter #(
   parameter int MAX_BURST      = 16,
   parameter int BEATS_PER_READ = 2,
   parameter int OUTST_W        = 6
) (
   input  logic         ddr2_clk,
   input  logic         RST,
   input  logic [1:0]   c_req,
   input  logic [1:0]   c_read,
   input  logic [1:0]   c_fin,
   input  logic [61:0]  c_addr,
   input  logic [511:0] c_data_write,
   input  logic [63:0]  c_mask,
   output logic [1:0]   c_ack,
   output logic [1:0]   c_valid,
   output logic [127:0] c_data_read,
   output logic         m_req,
   input  logic         m_ack,
   output logic [30:0]  m_addr,
   output logic         m_read,
   output logic [255:0] m_data_write,
   output logic [31:0]  m_mask,
   input  logic         m_valid,
   input  logic [127:0] m_data_read,
   output logic         owner,
   output logic         err_stray
);

   localparam int BW = $clog2(MAX_BURST) + 1;
   localparam int SW = OUTST_W + 2;   // headroom so the add never wraps before saturation
   localparam logic [SW-1:0] OMAX = SW'((1 << OUTST_W) - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DRAIN = 2'd2} state_t;

   state_t             state_q;
   logic               owner_q;
   logic               rr_q;
   logic [BW-1:0]      burst_q;
   logic [OUTST_W-1:0] outst_q;
   logic [OUTST_W-1:0] outst_d;
   logic               err_q;

   logic               in_grant;
   logic               ack_eff;
   logic               beat_ok;
   logic               rel;
   logic [SW-1:0]      sum;

   assign in_grant = (state_q == GRANT);
   // acks only mean something while we are presenting a request
   assign ack_eff  = in_grant & m_ack;
   // a beat with nothing outstanding belongs to nobody
   assign beat_ok  = m_valid & (outst_q != '0);

   // payload muxes follow the owner; m_req is what gates them at the port
   assign m_addr       = owner_q ? c_addr[61:31]          : c_addr[30:0];
   assign m_read       = owner_q ? c_read[1]              : c_read[0];
   assign m_data_write = owner_q ? c_data_write[511:256]  : c_data_write[255:0];
   assign m_mask       = owner_q ? c_mask[63:32]          : c_mask[31:0];
   assign m_req        = in_grant & c_req[owner_q];

   assign c_ack       = ack_eff ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign c_valid     = beat_ok ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign c_data_read = m_data_read;

   assign owner     = owner_q;
   assign err_stray = err_q;

   // issue and return are both applied in the same cycle, then clamped
   always_comb begin
      sum = SW'(outst_q);
      if (ack_eff && m_read) sum = sum + SW'(BEATS_PER_READ);
      if (beat_ok)           sum = sum - SW'(1);
      outst_d = (sum > OMAX) ? OMAX[OUTST_W-1:0] : sum[OUTST_W-1:0];
   end

   assign rel = (c_fin[owner_q] & ~m_ack) | ~c_req[owner_q] |
                (m_ack & (burst_q == BW'(MAX_BURST - 1)));

   always_ff @(posedge ddr2_clk or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         rr_q    <= 1'b0;
         burst_q <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         outst_q <= outst_d;
         if (m_valid && outst_q == '0) err_q <= 1'b1;
         case (state_q)
            IDLE: begin
               burst_q <= '0;
               if (c_req[rr_q]) begin
                  owner_q <= rr_q;
                  state_q <= GRANT;
               end else if (c_req[~rr_q]) begin
                  owner_q <= ~rr_q;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (m_ack) burst_q <= burst_q + BW'(1);
               if (rel) begin
                  rr_q    <= ~owner_q;
                  state_q <= (outst_d == '0) ? IDLE : DRAIN;
               end
            end
            DRAIN: begin
               if (outst_d == '0) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
module tb_ddr2_port_arbiter;

   logic         ddr2_clk = 1'b0;
   logic         RST = 1'b0;
   logic [1:0]   c_req = '0, c_read = '0, c_fin = '0;
   logic [61:0]  c_addr = '0;
   logic [511:0] c_data_write = '0;
   logic [63:0]  c_mask = '0;
   logic         m_ack = 1'b0, m_valid = 1'b0;
   logic [127:0] m_data_read = '0;

   logic [1:0]   c_ack, c_valid, c_ack4, c_valid4;
   logic [127:0] c_data_read, c_data_read4;
   logic         m_req, m_read, owner, err_stray;
   logic         m_req4, m_read4, owner4, err_stray4;
   logic [30:0]  m_addr, m_addr4;
   logic [255:0] m_data_write, m_data_write4;
   logic [31:0]  m_mask, m_mask4;

   int checks = 0;
   int errors = 0;

   always #5 ddr2_clk = ~ddr2_clk;

   ddr2_port_arbiter u_dut (
      .ddr2_clk(ddr2_clk), .RST(RST), .c_req(c_req), .c_read(c_read), .c_fin(c_fin),
      .c_addr(c_addr), .c_data_write(c_data_write), .c_mask(c_mask),
      .c_ack(c_ack), .c_valid(c_valid), .c_data_read(c_data_read),
      .m_req(m_req), .m_ack(m_ack), .m_addr(m_addr), .m_read(m_read),
      .m_data_write(m_data_write), .m_mask(m_mask), .m_valid(m_valid),
      .m_data_read(m_data_read), .owner(owner), .err_stray(err_stray));

   ddr2_port_arbiter #(.MAX_BURST(4)) u_dut4 (
      .ddr2_clk(ddr2_clk), .RST(RST), .c_req(c_req), .c_read(c_read), .c_fin(c_fin),
      .c_addr(c_addr), .c_data_write(c_data_write), .c_mask(c_mask),
      .c_ack(c_ack4), .c_valid(c_valid4), .c_data_read(c_data_read4),
      .m_req(m_req4), .m_ack(m_ack), .m_addr(m_addr4), .m_read(m_read4),
      .m_data_write(m_data_write4), .m_mask(m_mask4), .m_valid(m_valid),
      .m_data_read(m_data_read), .owner(owner4), .err_stray(err_stray4));

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b0;
      c_req = '0; c_read = '0; c_fin = '0; m_ack = 1'b0; m_valid = 1'b0;
      @(negedge ddr2_clk);
      @(negedge ddr2_clk);
      RST = 1'b1;
   endtask

   logic [1:0] exp2 [14];
   logic [30:0] a;

   initial begin
      exp2 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
               2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
               2'b01, 2'b01, 2'b01, 2'b01};

      // reset state
      do_reset();
      chk("rst_m_req",  m_req, 0);
      chk("rst_c_ack",  c_ack, 0);
      chk("rst_c_valid", c_valid, 0);
      chk("rst_owner",  owner, 0);
      chk("rst_err",    err_stray, 0);
      chk("rst_outst",  u_dut.outst_q, 0);

      // 1: c0 writes, ack every cycle -> release after 16, one idle, re-grant
      c_req = 2'b01; c_read = 2'b00; m_ack = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge ddr2_clk);
         a = 31'h0100_0000 + 31'(i * 7);
         c_addr = {31'h7abc_0000, a};
         #1;
         chk("t1_ack", c_ack, 2'b01);
         chk("t1_addr", m_addr, a);
      end
      @(negedge ddr2_clk);
      chk("t1_idle_req", m_req, 0);
      chk("t1_idle_ack", c_ack, 0);
      @(negedge ddr2_clk);
      chk("t1_regrant", c_ack, 2'b01);
      chk("t1_owner", owner, 0);

      // 2: both request, MAX_BURST=4 -> 4/4/4 alternation with idle gaps
      do_reset();
      c_req = 2'b11; m_ack = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(negedge ddr2_clk);
         chk("t2_ack4", c_ack4, exp2[i]);
      end

      // 3: c1 reads 3 acks, fin, 6 late beats; c0 waits until drain done
      do_reset();
      c_req = 2'b10; c_read = 2'b10; m_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ddr2_clk);
         chk("t3_ack", c_ack, 2'b10);
         chk("t3_read", m_read, 1);
      end
      @(negedge ddr2_clk);
      chk("t3_outst6", u_dut.outst_q, 6);
      m_ack = 1'b0; c_fin = 2'b10; c_req = 2'b11;
      @(negedge ddr2_clk);
      chk("t3_drain_req", m_req, 0);
      chk("t3_drain_own", owner, 1);
      repeat (8) @(negedge ddr2_clk);
      chk("t3_wait_req", m_req, 0);
      for (int k = 0; k < 6; k++) begin
         if (k != 0) @(negedge ddr2_clk);
         m_valid = 1'b1; m_data_read = 128'hbeef_0000 + 128'(k);
         #1;
         chk("t3_cvalid", c_valid, 2'b10);
         chk("t3_data", c_data_read, 128'hbeef_0000 + 128'(k));
         chk("t3_beat_req", m_req, 0);
      end
      @(negedge ddr2_clk);
      m_valid = 1'b0;
      #1;
      chk("t3_idle_req", m_req, 0);
      chk("t3_outst0", u_dut.outst_q, 0);
      @(negedge ddr2_clk);
      chk("t3_c0_grant", m_req, 1);
      chk("t3_c0_owner", owner, 0);
      chk("t3_no_stray", err_stray, 0);

      // 4: ack + beat in the same cycle, outst 2 -> 3
      do_reset();
      c_req = 2'b01; c_read = 2'b01; m_ack = 1'b1;
      @(negedge ddr2_clk);
      chk("t4_ack", c_ack, 2'b01);
      @(negedge ddr2_clk);
      chk("t4_outst2", u_dut.outst_q, 2);
      m_valid = 1'b1; m_data_read = 128'h55;
      #1;
      chk("t4_cvalid", c_valid, 2'b01);
      @(negedge ddr2_clk);
      chk("t4_outst3", u_dut.outst_q, 3);

      // 5: stray beat -> no c_valid, sticky err until reset
      do_reset();
      m_valid = 1'b1;
      #1;
      chk("t5_cvalid", c_valid, 0);
      @(negedge ddr2_clk);
      m_valid = 1'b0;
      chk("t5_err", err_stray, 1);
      repeat (3) @(negedge ddr2_clk);
      chk("t5_err_held", err_stray, 1);
      do_reset();
      chk("t5_err_clr", err_stray, 0);

      // 6: reset mid-grant with outst=4
      c_req = 2'b01; c_read = 2'b01; m_ack = 1'b1;
      repeat (3) @(negedge ddr2_clk);
      chk("t6_outst4", u_dut.outst_q, 4);
      chk("t6_req", m_req, 1);
      RST = 1'b0;
      #1;
      chk("t6_rst_req", m_req, 0);
      chk("t6_rst_outst", u_dut.outst_q, 0);
      chk("t6_rst_state", u_dut.state_q, 0);
      c_req = 2'b00; m_ack = 1'b0;
      @(negedge ddr2_clk);
      RST = 1'b1;
      m_valid = 1'b1;
      #1;
      chk("t6_late_cvalid", c_valid, 0);
      @(negedge ddr2_clk);
      m_valid = 1'b0;
      chk("t6_late_err", err_stray, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
